// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU functions,
// condition codes, status codes, register ids and the stage FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] IIADDQ  = 4'hC;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Execute-stage ALU: result = b op a, plus the zero/sign/overflow flags of that result.
// Function codes above XOR fall back to add.
module alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   fun_i,
    output logic [W-1:0] result_o,
    output logic         zf_o,
    output logic         sf_o,
    output logic         of_o
);

    logic [W-1:0] res;
    logic         ovf;

    always_comb begin
        res = b_i + a_i;
        ovf = (a_i[W-1] == b_i[W-1]) && (res[W-1] != b_i[W-1]);
        case (fun_i)
            ALUSUB: begin
                res = b_i - a_i;
                ovf = (a_i[W-1] != b_i[W-1]) && (res[W-1] != b_i[W-1]);
            end
            ALUAND: begin
                res = b_i & a_i;
                ovf = 1'b0;
            end
            ALUXOR: begin
                res = b_i ^ a_i;
                ovf = 1'b0;
            end
            default: ;
        endcase
    end

    assign result_o = res;
    assign zf_o     = (res == '0);
    assign sf_o     = res[W-1];
    assign of_o     = ovf;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition-code register, branch condition
// and RUN/HALT/FAULT freeze FSM. Optional iaddq support with macro IADDQ_EN.
module execute_stage
    import y86_pkg::*;
#(
    parameter int         W      = 64,
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    input  logic [2:0]   stat_in,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic [2:0]   cc,
    output logic         halted
);

    localparam logic [W-1:0] PLUS8  = W'(8);
    localparam logic [W-1:0] MINUS8 = '0 - PLUS8;

    state_e       state_q;
    logic [2:0]   cc_q;
    logic         halted_q;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_fun;
    logic         zf_new, sf_new, of_new;
    logic [2:0]   cc_d;
    logic         cc_op;
    logic         zf, sf, of;
    logic         cond;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            IRRMOVQ:          alu_a = valA;
            IIRMOVQ:          alu_a = valC;
            IRMMOVQ, IMRMOVQ: begin alu_a = valC;   alu_b = valB; end
            IOPQ:             begin alu_a = valA;   alu_b = valB; end
            ICALL, IPUSHQ:    begin alu_a = MINUS8; alu_b = valB; end
            IRET, IPOPQ:      begin alu_a = PLUS8;  alu_b = valB; end
`ifdef IADDQ_EN
            IIADDQ:           begin alu_a = valC;   alu_b = valB; end
`endif
            default: ;
        endcase
    end

    assign alu_fun = (icode == IOPQ) ? ifun : ALUADD;

    alu #(.W(W)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .fun_i    (alu_fun),
        .result_o (valE),
        .zf_o     (zf_new),
        .sf_o     (sf_new),
        .of_o     (of_new)
    );

    assign cc_d = {zf_new, sf_new, of_new};

`ifdef IADDQ_EN
    assign cc_op = (icode == IOPQ) || (icode == IIADDQ);
`else
    assign cc_op = (icode == IOPQ);
`endif

    // Branch/cmov conditions always look at the flags as they stood before this edge.
    assign {zf, sf, of} = cc_q;

    always_comb begin
        case (ifun)
            C_YES:   cond = 1'b1;
            C_LE:    cond = (sf ^ of) | zf;
            C_L:     cond = sf ^ of;
            C_E:     cond = zf;
            C_NE:    cond = ~zf;
            C_GE:    cond = ~(sf ^ of);
            C_G:     cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd = ((icode == IRRMOVQ) || (icode == IJXX)) ? cond : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            cc_q     <= CC_RST;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stat_in == SHLT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if ((stat_in == SADR) || (stat_in == SINS)) begin
                        state_q  <= S_FAULT;
                        halted_q <= 1'b1;
                    end else if ((stat_in == SAOK) && cc_op) begin
                        cc_q <= cc_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cc     = cc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors covering operand select,
// ALU ops, flags, conditions, freeze FSM and asynchronous reset. Honours IADDQ_EN.
module tb_execute_stage;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic [2:0]   stat_in;
    logic [W-1:0] valE;
    logic         cnd;
    logic [2:0]   cc;
    logic         halted;

    int n_vec = 0;
    int n_err = 0;

    execute_stage #(.W(W), .CC_RST(3'b100)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icode   (icode),
        .ifun    (ifun),
        .valA    (valA),
        .valB    (valB),
        .valC    (valC),
        .stat_in (stat_in),
        .valE    (valE),
        .cnd     (cnd),
        .cc      (cc),
        .halted  (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [2:0] st);
        icode   = ic;
        ifun    = fn;
        valA    = a;
        valB    = b;
        valC    = c;
        stat_in = st;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; stat_in = 3'd1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_cc", 64'(cc), 64'h4);
        check("reset_halted", 64'(halted), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add 1 + -1
        drive(4'h6, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd1);
        check("add_zero_valE", valE, 64'h0);
        tick();
        check("add_zero_cc", 64'(cc), 64'h4);

        // positive overflow
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 3'd1);
        check("add_ovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("add_ovf_cc", 64'(cc), 64'h3);
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jl_cc011", 64'(cnd), 64'h0);
        drive(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jmp_always", 64'(cnd), 64'h1);
        drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jle_cc011", 64'(cnd), 64'h0);
        tick();

        // sub 3 - 5
        drive(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 3'd1);
        check("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("sub_cc", 64'(cc), 64'h2);
        drive(4'h2, 4'h2, 64'h0, 64'h0, 64'h0, 3'd1);
        check("cmovl_cc010", 64'(cnd), 64'h1);
        drive(4'h2, 4'h6, 64'h0, 64'h0, 64'h0, 3'd1);
        check("cmovg_cc010", 64'(cnd), 64'h0);
        drive(4'h2, 4'h4, 64'h0, 64'h0, 64'h0, 3'd1);
        check("cmovne_cc010", 64'(cnd), 64'h1);
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jxx_bad_ifun", 64'(cnd), 64'h0);
        drive(4'h5, 4'h0, 64'h0, 64'h0, 64'h0, 3'd1);
        check("cnd_other_icode", 64'(cnd), 64'h0);
        tick();
        check("cc_hold_non_op", 64'(cc), 64'h2);

        // and / xor / ifun>3
        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 64'h0, 3'd1);
        check("and_valE", valE, 64'h0);
        tick();
        check("and_cc", 64'(cc), 64'h4);
        drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 3'd1);
        check("je_cc100", 64'(cnd), 64'h1);
        drive(4'h6, 4'h3, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 3'd1);
        check("xor_valE", valE, 64'h8000_0000_0000_0001);
        tick();
        check("xor_cc", 64'(cc), 64'h2);
        drive(4'h6, 4'h7, 64'h2, 64'h3, 64'h0, 3'd1);
        check("op_ifun7_valE", valE, 64'h5);
        tick();
        check("op_ifun7_cc", 64'(cc), 64'h0);

        // operand selection for non-OPq instructions
        drive(4'hA, 4'h0, 64'h55, 64'h100, 64'h77, 3'd1);
        check("pushq_valE", valE, 64'hF8);
        drive(4'hB, 4'h0, 64'h55, 64'h100, 64'h77, 3'd1);
        check("popq_valE", valE, 64'h108);
        drive(4'h8, 4'h0, 64'h55, 64'h100, 64'h77, 3'd1);
        check("call_valE", valE, 64'hF8);
        drive(4'h9, 4'h0, 64'h55, 64'h100, 64'h77, 3'd1);
        check("ret_valE", valE, 64'h108);
        drive(4'h3, 4'h0, 64'h55, 64'h100, 64'h1234, 3'd1);
        check("irmovq_valE", valE, 64'h1234);
        drive(4'h2, 4'h0, 64'hABCD, 64'h100, 64'h1234, 3'd1);
        check("rrmovq_valE", valE, 64'hABCD);
        drive(4'h4, 4'h0, 64'h55, 64'h10, 64'h20, 3'd1);
        check("rmmovq_valE", valE, 64'h30);
        drive(4'h0, 4'h0, 64'h55, 64'h10, 64'h20, 3'd1);
        check("halt_icode_valE", valE, 64'h0);
        tick();
        check("cc_after_mem_ops", 64'(cc), 64'h0);

        // iaddq
        drive(4'hC, 4'h0, 64'h55, 64'hFFFF_FFFF_FFFF_FFFB, 64'h5, 3'd1);
        check("iaddq_valE", valE, 64'h0);
        tick();
`ifdef IADDQ_EN
        check("iaddq_cc", 64'(cc), 64'h4);
`else
        check("iaddq_cc", 64'(cc), 64'h0);
`endif

        // negative overflow on sub
        drive(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 3'd1);
        check("sub_ovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        check("sub_ovf_cc", 64'(cc), 64'h1);
        drive(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jge_cc001", 64'(cnd), 64'h0);
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 3'd1);
        check("jl_cc001", 64'(cnd), 64'h1);

        // fault on INS with a simultaneous OPq
        drive(4'h6, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd4);
        check("fault_edge_valE", valE, 64'h0);
        check("fault_pre_halted", 64'(halted), 64'h0);
        tick();
        check("fault_halted", 64'(halted), 64'h1);
        check("fault_cc", 64'(cc), 64'h1);
        drive(4'h6, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd1);
        tick();
        check("frozen_cc", 64'(cc), 64'h1);
        check("frozen_halted", 64'(halted), 64'h1);
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 3'd1);
        check("frozen_cnd", 64'(cnd), 64'h1);

        // async reset between edges
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_halted", 64'(halted), 64'h0);
        check("async_rst_cc", 64'(cc), 64'h4);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // HLT with OPq that would set 011 if cc loaded
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 3'd2);
        tick();
        check("hlt_halted", 64'(halted), 64'h1);
        check("hlt_cc", 64'(cc), 64'h4);

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 3'd3);
        tick();
        check("adr_halted", 64'(halted), 64'h1);
        check("adr_cc", 64'(cc), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter W, default 64, data path width in bits.
REQ-002 SHALL have parameter CC_RST, default 3'b100, reset value of {ZF,SF,OF}.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports icode, ifun  input  4 each  instruction code and function from fetch.
REQ-006 SHALL have ports valA, valB  input  W each  register operands from decode; valC  input  W  immediate.
REQ-007 SHALL have port stat_in  input  3  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-008 SHALL have ports valE  output  W  ALU result; cnd  output  1  condition result.
REQ-009 SHALL have ports cc  output  3  registered {ZF,SF,OF}; halted  output  1  stage frozen.

Function
REQ-010 SHALL select aluA: valA for icode 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B; 0 otherwise.
REQ-011 SHALL select aluB: valB for icode 4,5,6,8,9,A,B; 0 for 2,3 and all others.
REQ-012 SHALL compute valE = aluB op aluA, op = ifun for icode 6 (0 add, 1 sub, 2 and, 3 xor), add otherwise, modulo 2^W.
REQ-013 SHALL compute the new flags: ZF = (result==0), SF = result[W-1], OF = signed overflow for add/sub, 0 for and/xor.
REQ-014 SHALL use OPq ifun values above 3 as add for valE and flags.
REQ-015 SHALL evaluate cnd combinationally from the registered cc (pre-update) for icode 2 and 7.
REQ-016 SHALL decode the conditions as: ifun 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; other ifun 0.
REQ-017 SHALL drive cnd=0 for all other icodes.
REQ-018 SHALL have an FSM with states RUN, HALT and FAULT.
REQ-019 SHALL transition RUN->HALT on stat_in==HLT and RUN->FAULT on stat_in==ADR or INS; HALT and FAULT SHALL be exited only by reset.
REQ-020 SHALL load cc with the new flags on a clock edge only when state==RUN, icode==6 and stat_in==AOK.
REQ-021 SHALL not change cc on the edge that takes RUN->HALT/FAULT (simultaneous OPq with a non-AOK status).
REQ-022 SHALL hold cc frozen in HALT/FAULT, keep valE and cnd combinational, and drive halted = (state!=RUN).

Reset
REQ-023 SHALL, on rst_n low, immediately set state=RUN, cc=CC_RST and halted=0, independent of clk.
REQ-024 SHALL abandon any in-flight cc update when reset is asserted mid-cycle; first update after rst_n rises SHALL be at the next qualifying edge.

Configuration
REQ-025 SHALL, with IADDQ_EN defined, treat icode C as iaddq: aluA=valC, aluB=valB, op add, cc updated under the REQ-020 rules with icode C.
REQ-026 SHALL, without IADDQ_EN, treat icode C like an unknown icode: valE=0, cnd=0, cc unchanged.

Structure
REQ-027 SHALL place icode constants, ALU function codes, condition codes, stat codes and register ids (RSP=4, RNONE=F) in a shared package y86_pkg.
REQ-028 SHALL implement ALU and flag generation in sub-module alu; the CC register, condition logic and FSM SHALL stay in execute_stage.

Verification
REQ-029 SHALL be verified by: after reset, icode=6 ifun=0 valA=1 valB=-1, AOK, one edge -> valE=0, cc=3'b100.
REQ-030 SHALL be verified by: OPq add valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc=3'b011; then icode=7 ifun=2 -> cnd=0.
REQ-031 SHALL be verified by: OPq sub valB=3 valA=5 -> valE=-2, cc=3'b010; next cycle icode=2 ifun=2 -> cnd=1, icode=2 ifun=6 -> cnd=0.
REQ-032 SHALL be verified by: icode=A valB=0x100 -> valE=0xF8; icode=B valB=0x100 -> valE=0x108; cc unchanged.
REQ-033 SHALL be verified by: OPq with stat_in=INS -> halted=1 next edge, cc unchanged; further AOK OPq -> cc frozen; rst_n pulse low -> halted=0, cc=CC_RST without a clock edge.
REQ-034 SHALL be verified by: icode=C valC=5 valB=-5 -> with IADDQ_EN valE=0, cc=3'b100; without it valE=0, cc unchanged.
